sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Input-side conditioner for the lab board's slide switches and pushbuttons.
- Takes raw, asynchronous, bouncing `sw` lines and produces, per bit:
  - a synchronized, debounced level;
  - single-cycle rise and fall pulses.
- Sits between the board pins and any sequential consumer (counters, FSMs, LED drivers), so no downstream logic samples a raw switch.

Parameters:
- WIDTH, 4: number of independent switch bits.
- STABLE_CYCLES, 1000000: consecutive clock cycles an input must hold a new value before it is accepted. This is 20 ms at 50 MHz. Legal range is ≥ 2.
- CNT_W, 20: stability counter width. Must satisfy 2^CNT_W ≥ STABLE_CYCLES.

Ports:
- clk, input, 1: system clock. All state is updated on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- sw, input, WIDTH: raw switch/button pins. Asynchronous to clk, may bounce.
- sw_level, output, WIDTH: debounced level per bit.
- sw_rise, output, WIDTH: one-cycle pulse when a bit's debounced level goes 0→1.
- sw_fall, output, WIDTH: one-cycle pulse when a bit's debounced level goes 1→0.

Behaviour:
- Every bit is fully independent. The per-bit description below applies to bits 0..WIDTH-1.

Reset:
- rst=1 immediately forces all of the following, regardless of clk:
  - sync_q1=0, sync_q2=0;
  - state=LOW, cnt=0;
  - sw_level=0, sw_rise=0, sw_fall=0.
- Reset asserted mid-count discards the count. After release the bit is LOW even if sw is held at 1; that 1 must then qualify normally, producing one rise.

Synchronizer:
- Two flops: sync_q1 <= sw[i]; sync_q2 <= sync_q1.
- The FSM sees only sync_q2.

FSM (4 states):
- LOW:
  - sync_q2=1 → CHK_HI with cnt <= 0.
  - Otherwise stay in LOW.
- CHK_HI:
  - sync_q2=0 → LOW with cnt <= 0 (glitch rejected, no pulse).
  - sync_q2=1 and cnt = STABLE_CYCLES-1 → HIGH, sw_level <= 1, sw_rise <= 1.
  - Otherwise cnt <= cnt+1.
- HIGH: mirror of LOW. sync_q2=0 → CHK_LO with cnt <= 0.
- CHK_LO: mirror of CHK_HI.
  - sync_q2=1 → HIGH (glitch rejected).
  - sync_q2=0 and cnt = STABLE_CYCLES-1 → LOW, sw_level <= 0, sw_fall <= 1.
  - Otherwise cnt <= cnt+1.

Pulses:
- sw_rise and sw_fall are registered and high for exactly one cycle, on the same cycle sw_level changes.
- They default to 0 on every other cycle.
- rise and fall are never both high on one bit in the same cycle.

Latency:
- Take edge 1 as the first clk edge that samples the new sw value, and assume sw is stable from then on.
- sw_level and the pulse become visible after edge STABLE_CYCLES+3.

Glitch filtering:
- Any return to the old value during CHK_* restarts qualification from zero.
- A bounce train shorter than STABLE_CYCLES cycles between edges never changes the output.

Counter:
- cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- cnt is held at 0 in the LOW and HIGH states.

Simultaneous events:
- Different bits may qualify on the same cycle. Each bit raises its own pulse, with no arbitration.

Decomposition:
- Shared package board_io_pkg holds:
  - the 2-bit state encoding: LOW=2'd0, CHK_HI=2'd1, HIGH=2'd2, CHK_LO=2'd3;
  - the default STABLE_CYCLES for a 50 MHz board clock.
- One sub-module, sw_debounce_bit:
  - contains the synchronizer, FSM and counter for a single bit, with parameters STABLE_CYCLES and CNT_W;
  - is instantiated WIDTH times by a generate loop in sw_debounce.

Test Plan (STABLE_CYCLES=8, CNT_W=4, WIDTH=4 in simulation):
- Reset, then sw=4'b0000 for 20 cycles → sw_level=0, no pulses. Assert rst mid-cycle → outputs 0 before the next clk edge.
- sw[0] 0→1, held → sw_level[0]=1 after edge 11. sw_rise[0]=1 for exactly that one cycle. All other bits stay 0.
- sw[1] bounces 1,0,1,0 with 3-cycle segments, then holds 1 → no rise during bouncing. Exactly one sw_rise[1], 11 edges after the final 0→1.
- sw[2] held 1 until sw_level[2]=1, then a 5-cycle 0 glitch → sw_level[2] stays 1, no sw_fall. A later 8+ cycle 0 → exactly one sw_fall[2].
- sw=4'b1111 applied in one cycle → all four sw_level bits rise on the same edge, with sw_rise=4'b1111 for one cycle.
- sw[3]=1 held. Pulse rst at cycle 6 of CHK_HI, then release → no rise before release. sw_rise[3] occurs 11 edges after release.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared definitions for the lab-board input conditioning blocks.
package board_io_pkg;

    // Per-bit debounce state encoding.
    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } db_state_t;

    // Board clock and the settle time a mechanical contact needs.
    localparam int BOARD_CLK_HZ = 50_000_000;
    localparam int DEBOUNCE_MS  = 20;

    // 20 ms at 50 MHz = 1,000,000 cycles; a 20-bit counter covers it.
    localparam int DEFAULT_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_CNT_W         = 20;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, qualification FSM and
// stability counter. The debounced level and edge pulses are registered.
module sw_debounce_bit
    import board_io_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Count value on the cycle that completes qualification.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync_q1;
    logic             r_sync_q2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Bring the asynchronous pin into the clk domain before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q1 <= 1'b0;
            r_sync_q2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so q2 takes the old q1, giving two real flop stages.
            r_sync_q1 <= i_sw;
            r_sync_q2 <= r_sync_q1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state logic: a new value must hold for STABLE_CYCLES to be accepted.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            ST_LOW: begin
                if (r_sync_q2) begin
                    w_state_nxt = ST_CHK_HI;
                end
            end

            ST_CHK_HI: begin
                if (!r_sync_q2) begin
                    // Bounced back before qualifying: drop silently.
                    w_state_nxt = ST_LOW;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_HIGH: begin
                if (!r_sync_q2) begin
                    w_state_nxt = ST_CHK_LO;
                end
            end

            ST_CHK_LO: begin
                if (r_sync_q2) begin
                    w_state_nxt = ST_HIGH;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_LOW;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH independent switch/button inputs. Each bit yields a clean
// level plus one-cycle rise/fall pulses aligned with the level change.
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    // One fully independent debouncer per bit; no arbitration between bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_sw    (sw[gi]),
            .o_level (sw_level[gi]),
            .o_rise  (sw_rise[gi]),
            .o_fall  (sw_fall[gi])
        );
    end

endmodule
